// File: rtl/apb_mem_slave.sv
// APB4 memory slave: byte-strobed writes, registered read data, configurable wait states
// and out-of-range error reporting. PREADY/PSLVERR/PRDATA all come straight from flops.
module apb_mem_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned StrbW    = DATA_WIDTH / 8;
  localparam int unsigned OffsW    = (StrbW > 1) ? $clog2(StrbW) : 0;
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WcntInit = 4'(WAIT_STATES);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]        strb_q, strb_d;
  logic                    err_q, err_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    mem_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   addr_idx;
  logic                    in_range;
  logic                    setup;
  logic                    access;

  assign addr_idx = PADDR >> OffsW;
  assign in_range = addr_idx < ADDR_WIDTH'(DEPTH);
  assign setup    = PSEL & ~PENABLE;
  assign access   = PSEL & PENABLE;

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (setup) begin
          state_d   = StAccess;
          idx_d     = addr_idx[IdxW-1:0];
          write_d   = PWRITE;
          wdata_d   = PWDATA;
          strb_d    = PSTRB;
          err_d     = ~in_range;
          wcnt_d    = WcntInit;
          // PREADY is registered, so raise it one cycle ahead of the completing access cycle
          pready_d  = (WcntInit == 4'd0);
          pslverr_d = ~in_range & (WcntInit == 4'd0);
          if (!PWRITE) begin
            prdata_d = in_range ? mem[addr_idx[IdxW-1:0]] : '0;
          end
        end
      end
      StAccess: begin
        if (access) begin
          if (wcnt_q != 4'd0) begin
            wcnt_d    = wcnt_q - 4'd1;
            pready_d  = (wcnt_q == 4'd1);
            pslverr_d = err_q & (wcnt_q == 4'd1);
          end else begin
            mem_we  = write_q & ~err_q;
            state_d = StIdle;
          end
        end else begin
          // Master abort: drop the transfer without touching memory
          state_d = StIdle;
          wcnt_d  = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= StIdle;
      wcnt_q    <= 4'd0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Storage is intentionally not reset
  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int i = 0; i < StrbW; i++) begin
        if (strb_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign PRDATA  = prdata_q;
  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: three instances with 0, 2 and 3 wait states share
// the APB bus except for PSEL; each vector carries a hand-computed expected value.
module tb_apb_mem_slave;

  logic        clk;
  logic        prst_n;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic [2:0]  pready;
  logic [2:0]  pslverr;

  int n_checks;
  int n_errors;

  logic [31:0] rd;
  logic        er;
  int          cyc;

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .PCLK(clk), .PRESETn(prst_n), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0])
  );

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .PCLK(clk), .PRESETn(prst_n), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1])
  );

  apb_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .PCLK(clk), .PRESETn(prst_n), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata[2]),
    .PREADY(pready[2]), .PSLVERR(pslverr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; drives setup now, returns at posedge+1 of the cycle after PREADY.
  task automatic apb_xfer(input int sel, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err, output int cycles);
    psel     = 3'b000;
    psel[sel] = 1'b1;
    penable  = 1'b0;
    pwrite   = wr;
    paddr    = addr;
    pwdata   = data;
    pstrb    = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    cycles  = 2;
    while (!pready[sel]) begin
      if (cycles >= 20) begin
        check_eq("xfer_timeout", 32'(cycles), 32'd0);
        break;
      end
      check_eq("wait_slverr", 32'(pslverr[sel]), 32'd0);
      @(posedge clk); #1;
      cycles++;
    end
    rdata = prdata[sel];
    err   = pslverr[sel];
    @(posedge clk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    check_eq("pready_one_cycle", 32'(pready[sel]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    prst_n   = 1'b1;
    psel     = 3'b000;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = '0;
    pwdata   = '0;
    pstrb    = '0;
    #2 prst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq("reset_pready", 32'(pready[i]), 32'd0);
      check_eq("reset_pslverr", 32'(pslverr[i]), 32'd0);
      check_eq("reset_prdata", prdata[i], 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) prst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read, zero wait states
    apb_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, cyc);
    check_eq("wr10_cycles", 32'(cyc), 32'd2);
    check_eq("wr10_err", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
    check_eq("rd10_data", rd, 32'hDEADBEEF);
    check_eq("rd10_err", 32'(er), 32'd0);
    check_eq("rd10_cycles", 32'(cyc), 32'd2);

    // Byte strobes
    apb_xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, cyc);
    apb_xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, rd, er, cyc);
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
    check_eq("strb_merge", rd, 32'h11BB33DD);

    // All-zero strobe: completes cleanly, no change
    apb_xfer(0, 1'b1, 32'h20, 32'h00000000, 4'h0, rd, er, cyc);
    check_eq("strb0_err", 32'(er), 32'd0);
    apb_xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
    check_eq("strb0_data", rd, 32'h11BB33DD);

    // Out of range: index 256 must not alias word 0
    apb_xfer(0, 1'b1, 32'h0, 32'h12345678, 4'hF, rd, er, cyc);
    apb_xfer(0, 1'b0, 32'h400, 32'h0, 4'h0, rd, er, cyc);
    check_eq("oor_rd_err", 32'(er), 32'd1);
    check_eq("oor_rd_data", rd, 32'd0);
    apb_xfer(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
    check_eq("oor_wr_err", 32'(er), 32'd1);
    check_eq("oor_wr_cycles", 32'(cyc), 32'd2);
    apb_xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, cyc);
    check_eq("oor_word0_data", rd, 32'h12345678);
    check_eq("oor_next_err", 32'(er), 32'd0);

    // Three wait states: 5-cycle transfers
    apb_xfer(2, 1'b1, 32'h50, 32'hA5A50001, 4'hF, rd, er, cyc);
    check_eq("ws3_wr_cycles", 32'(cyc), 32'd5);
    apb_xfer(2, 1'b0, 32'h50, 32'h0, 4'h0, rd, er, cyc);
    check_eq("ws3_rd_cycles", 32'(cyc), 32'd5);
    check_eq("ws3_rd_data", rd, 32'hA5A50001);
    check_eq("ws3_rd_err", 32'(er), 32'd0);

    // Abort during a wait cycle, two wait states
    apb_xfer(1, 1'b1, 32'h30, 32'h01020304, 4'hF, rd, er, cyc);
    check_eq("ws2_wr_cycles", 32'(cyc), 32'd4);
    psel    = 3'b010;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h30;
    pwdata  = 32'hFFFFFFFF;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    check_eq("abort_acc1_pready", 32'(pready[1]), 32'd0);
    @(posedge clk); #1;
    psel    = 3'b000;
    penable = 1'b0;
    check_eq("abort_acc2_pready", 32'(pready[1]), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("abort_no_pready", 32'(pready[1]), 32'd0);
    end
    apb_xfer(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, cyc);
    check_eq("abort_mem_kept", rd, 32'h01020304);
    check_eq("abort_next_cycles", 32'(cyc), 32'd4);

    // Asynchronous reset in the completing access cycle of a write
    apb_xfer(0, 1'b1, 32'h40, 32'h00000055, 4'hF, rd, er, cyc);
    apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, cyc);
    check_eq("rst_pre_data", rd, 32'h00000055);
    psel    = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 32'h40;
    pwdata  = 32'hCAFEF00D;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    check_eq("rst_pre_pready", 32'(pready[0]), 32'd1);
    #2 prst_n = 1'b0;
    #1;
    check_eq("rst_async_pready", 32'(pready[0]), 32'd0);
    check_eq("rst_async_pslverr", 32'(pslverr[0]), 32'd0);
    check_eq("rst_async_prdata", prdata[0], 32'd0);
    psel    = 3'b000;
    penable = 1'b0;
    @(posedge clk);
    @(negedge clk) prst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, cyc);
    check_eq("rst_word_kept", rd, 32'h00000055);
    check_eq("rst_after_err", 32'(er), 32'd0);
    check_eq("rst_after_cycles", 32'(cyc), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
